// File: rtl/hazard_pkg.sv
// Shared encodings for the execute-stage hazard unit: forward selects and FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package hazard_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hazardState_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Private M/W destination pipeline plus the operand forward-select compare.
// Latency: selects are combinational from registered M/W state; M and W never stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rd_E,
  input  logic                  RegWrite_E,
  input  logic                  FlushE,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E
);
  logic [REG_ADDR_W-1:0] rdM, rdW;
  logic                  regWriteM, regWriteW;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdM       <= '0;
      rdW       <= '0;
      regWriteM <= 1'b0;
      regWriteW <= 1'b0;
    end else begin
      rdM       <= Rd_E;
      regWriteM <= RegWrite_E & ~FlushE;
      rdW       <= rdM;
      regWriteW <= regWriteM;
    end
  end

  // M wins over W; x0 is hardwired so it never forwards.
  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs,
                                        input logic [REG_ADDR_W-1:0] dM,
                                        input logic                  wM,
                                        input logic [REG_ADDR_W-1:0] dW,
                                        input logic                  wW);
    if (wM && dM != '0 && dM == rs)      return FWD_MEM;
    else if (wW && dW != '0 && dW == rs) return FWD_WB;
    else                                 return FWD_REG;
  endfunction

  always_comb begin
    ForwardA_E = fwdSel(Rs1_E, rdM, regWriteM, rdW, regWriteW);
    ForwardB_E = fwdSel(Rs2_E, rdM, regWriteM, rdW, regWriteW);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Execute-stage hazard control: forwarding, load-use bubbles, taken-branch flushes.
// Latency: all outputs combinational from E/D inputs and registered state; optional
// saturating perf counters (StallCount/FlushCount) are built only with HAZARD_PERF_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] Rd_E,
  input  logic                  RegWrite_E,
  input  logic                  ResultSel_E,
  input  logic                  PCSourceE,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);
  hazardState_t state;
  logic [2:0]   cnt;
  logic         loadUse;
  logic         stallNow;

  assign loadUse = RegWrite_E & ResultSel_E & (Rd_E != '0) &
                   ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

  // A taken branch kills whatever the stall would have protected, so it takes precedence.
  always_comb begin
    stallNow = 1'b0;
    if (!PCSourceE) stallNow = (state == ST_STALL) | loadUse;
  end

  assign StallF = stallNow;
  assign StallD = stallNow;
  assign FlushD = PCSourceE;
  assign FlushE = PCSourceE | stallNow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else if (PCSourceE) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (loadUse && LOAD_STALL > 1) begin
            state <= ST_STALL;
            cnt   <= 3'(LOAD_STALL - 1);
          end
        end
        ST_STALL: begin
          if (cnt == 3'd1) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) scoreboard (
    .clk        (clk),
    .rst        (rst),
    .Rd_E       (Rd_E),
    .RegWrite_E (RegWrite_E),
    .FlushE     (FlushE),
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallNow && stallCnt != '1)  stallCnt <= stallCnt + 1'b1;
      if (PCSourceE && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (LOAD_STALL 1 and 3, CNT_W 4) share stimulus.
module tb_hazard_control_unit;
  typedef struct packed {
    logic       r;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       rw, rsel, pcs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E;
  logic       RegWrite_E, ResultSel_E, PCSourceE;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic       sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
  logic [3:0] sc1, fc1, sc3, fc3;
  logic [31:0] obs;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expQ[$];

  // reference state per instance: index 0 -> LOAD_STALL 1, index 1 -> LOAD_STALL 3
  int         ls[2] = '{1, 3};
  logic [4:0] mRdM[2], mRdW[2];
  logic       mRwM[2], mRwW[2], mSt[2], mStl[2], mFe[2], mLu[2];
  logic [2:0] mCnt[2];
  logic [3:0] mSc[2], mFc[2];
  vec_t       cur;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .ResultSel_E(ResultSel_E), .PCSourceE(PCSourceE),
    .ForwardA_E(fa1), .ForwardB_E(fb1), .StallF(sf1), .StallD(sd1), .FlushD(fd1),
    .FlushE(fe1), .StallCount(sc1), .FlushCount(fc1));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .ResultSel_E(ResultSel_E), .PCSourceE(PCSourceE),
    .ForwardA_E(fa3), .ForwardB_E(fb3), .StallF(sf3), .StallD(sd3), .FlushD(fd3),
    .FlushE(fe3), .StallCount(sc3), .FlushCount(fc3));

  assign obs = {fa1, fb1, sf1, sd1, fd1, fe1, sc1, fc1,
                fa3, fb3, sf3, sd3, fd3, fe3, sc3, fc3};

  function automatic vec_t mk(input logic r, input int rs1d, input int rs2d, input int rs1e,
                              input int rs2e, input int rde, input logic rw, input logic rsel,
                              input logic pcs);
    vec_t v;
    v.r = r; v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e);
    v.rs2e = 5'(rs2e); v.rde = 5'(rde); v.rw = rw; v.rsel = rsel; v.pcs = pcs;
    return v;
  endfunction

  function automatic logic [1:0] refFwd(input int k, input logic [4:0] rs);
    if (mRwM[k] && mRdM[k] != 5'd0 && mRdM[k] == rs) return 2'b10;
    if (mRwW[k] && mRdW[k] != 5'd0 && mRdW[k] == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Apply one input vector and push the expected outputs of both instances.
  task automatic drive(input vec_t v);
    logic [15:0] e[2];
    logic [3:0]  scOut, fcOut;
    cur = v;
    rst = v.r; Rs1_D = v.rs1d; Rs2_D = v.rs2d; Rs1_E = v.rs1e; Rs2_E = v.rs2e;
    Rd_E = v.rde; RegWrite_E = v.rw; ResultSel_E = v.rsel; PCSourceE = v.pcs;
    for (int k = 0; k < 2; k++) begin
      mLu[k]  = v.rw & v.rsel & (v.rde != 5'd0) & ((v.rde == v.rs1d) | (v.rde == v.rs2d));
      mStl[k] = !v.pcs && (mSt[k] || mLu[k]);
      mFe[k]  = v.pcs || mStl[k];
`ifdef HAZARD_PERF_EN
      scOut = mSc[k]; fcOut = mFc[k];
`else
      scOut = 4'd0; fcOut = 4'd0;
`endif
      e[k] = {refFwd(k, v.rs1e), refFwd(k, v.rs2e), mStl[k], mStl[k], v.pcs, mFe[k],
              scOut, fcOut};
    end
    expQ.push_back({e[0], e[1]});
  endtask

  // Advance one clock and step the reference state with the inputs just applied.
  task automatic clockIt();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cur.r) begin
        mRdM[k] = 0; mRdW[k] = 0; mRwM[k] = 0; mRwW[k] = 0;
        mSt[k] = 0; mCnt[k] = 0; mSc[k] = 0; mFc[k] = 0;
      end else begin
        mRdW[k] = mRdM[k]; mRwW[k] = mRwM[k];
        mRdM[k] = cur.rde; mRwM[k] = cur.rw & ~mFe[k];
        if (mStl[k] && mSc[k] != 4'hF) mSc[k] = mSc[k] + 4'd1;
        if (cur.pcs && mFc[k] != 4'hF) mFc[k] = mFc[k] + 4'd1;
        if (cur.pcs) begin
          mSt[k] = 0; mCnt[k] = 0;
        end else if (mSt[k]) begin
          if (mCnt[k] == 3'd1) begin mSt[k] = 0; mCnt[k] = 0; end
          else mCnt[k] = mCnt[k] - 3'd1;
        end else if (mLu[k] && ls[k] > 1) begin
          mSt[k] = 1; mCnt[k] = 3'(ls[k] - 1);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic [31:0] exp;
    // first cycle: DUT state is unknown until the reset edge, so its prediction is dropped
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; exp = expQ.pop_front();
    clockIt();
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 3, 4, 5, 6, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_reset[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_alu_forward();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(0, 0, 0, 1, 2, 5, 1, 0, 0));   // add x5
    v.push_back(mk(0, 0, 0, 5, 2, 0, 0, 0, 0));   // x5 in M -> A=10
    v.push_back(mk(0, 0, 0, 5, 2, 0, 0, 0, 0));   // x5 in W -> A=01
    v.push_back(mk(0, 0, 0, 5, 5, 0, 0, 0, 0));   // retired -> 00
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_alu_forward[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_mw_same_rd();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 7, 7, 0, 1, 0, 0));   // x7 in M and W -> M wins; Rd=0 writes
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));   // x0 in M and W -> never forwarded
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_mw_same_rd[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(0, 9, 9, 0, 0, 3, 1, 1, 0));   // load x3, no dependant in D
    v.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));   // load now in W -> A=01
    v.push_back(mk(0, 0, 3, 0, 0, 3, 1, 1, 0));   // load x3, Rs2_D=3 -> stall
    v.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 3, 0, 3, 0, 0, 1, 1, 0));   // x0 load never stalls
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_load_use[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_stall_reset();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(0, 4, 0, 0, 0, 4, 1, 1, 0));   // full 3-bubble stall
    v.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 6, 0, 0, 0, 6, 1, 1, 0));   // second stall, reset in its 2nd cycle
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_stall_reset[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(0, 4, 0, 0, 0, 4, 1, 1, 1));   // branch beats load-use
    v.push_back(mk(0, 0, 0, 4, 0, 0, 0, 0, 0));   // flushed load must not forward
    v.push_back(mk(0, 8, 0, 0, 0, 8, 1, 1, 0));   // enter stall
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));   // stray branch during stall -> RUN
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_branch[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  task automatic test_saturation();
    vec_t v[$];
    logic [31:0] exp;
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 20; n++) v.push_back(mk(0, 3, 0, 0, 0, 3, 1, 1, 0));
    for (int n = 0; n < 18; n++) v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); #1;
      exp = expQ.pop_front(); vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL test_saturation[%0d] got %h want %h", i, obs, exp);
      end
      clockIt();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mRdM[k] = 0; mRdW[k] = 0; mRwM[k] = 0; mRwW[k] = 0; mSt[k] = 0;
      mStl[k] = 0; mFe[k] = 0; mLu[k] = 0; mCnt[k] = 0; mSc[k] = 0; mFc[k] = 0;
    end
    #1;
    test_reset();
    test_alu_forward();
    test_mw_same_rd();
    test_load_use();
    test_stall_reset();
    test_branch();
    test_saturation();
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got %0d left want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
